// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between NREQ write requesters, the write arbiter and the FIFO write port.
// Latency: none (signal bundle only).
// Backpressure: fifo_full from the FIFO side gates ack/fifo_wr inside the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int SW   = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic               fifo_full;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_data;
  logic [SW-1:0]      fifo_src;
  logic               busy;

  // Requester/FIFO side: drives requests, data and the full flag.
  modport master (
    output req, req_data, fifo_full,
    input  gnt, ack, fifo_wr, fifo_data, fifo_src, busy
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, fifo_full,
    output gnt, ack, fifo_wr, fifo_data, fifo_src, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters, bursts of up to MAX_BURST beats.
// Latency: req in idle cycle -> grant next cycle; ack/fifo_wr/fifo_data combinational in the grant cycle.
// Backpressure: fifo_full blocks ack in the same cycle; grant is held with no timeout while full.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int SW        = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fifo_wr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {IDLE, BURST} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   owner_q, owner_d;
  logic [SW-1:0]   last_q, last_d;
  logic [SW-1:0]   src_q, src_d;
  logic [3:0]      beat_q, beat_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic [SW-1:0]   pick;
  logic            found;
  logic [NREQ-1:0] ack_w;
  logic [DW-1:0]   data_w;

  // Round-robin pick: first set request scanning last+1, last+2, ... modulo NREQ.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!found && bus.req[(int'(last_q) + off) % NREQ]) begin
        found = 1'b1;
        pick  = SW'((int'(last_q) + off) % NREQ);
      end
    end
  end

  // Beat acceptance is purely combinational so a FIFO full rise blocks the same cycle.
  always_comb begin
    ack_w  = gnt_q & bus.req & {NREQ{~bus.fifo_full}};
    data_w = '0;
    if (|gnt_q) begin
      data_w = bus.req_data[owner_q*DW +: DW];
    end
  end

  assign bus.ack       = ack_w;
  assign bus.fifo_wr   = |ack_w;
  assign bus.fifo_data = data_w;
  assign bus.gnt       = gnt_q;
  assign bus.fifo_src  = src_q;
  assign bus.busy      = (state_q == BURST);

  // Next-state: grant on any request in IDLE, count beats, release on last beat or owner drop.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    src_d   = src_q;
    beat_d  = beat_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          owner_d = pick;
          src_d   = pick;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          beat_d  = 4'd0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!bus.req[owner_q] ||
            (ack_w[owner_q] && beat_q == 4'(MAX_BURST - 1))) begin
          // Owner dropped its request or just finished its final beat.
          gnt_d   = '0;
          last_d  = owner_q;
          beat_d  = 4'd0;
          state_d = IDLE;
        end else if (ack_w[owner_q]) begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers; last starts at NREQ-1 so requester 0 has first priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= SW'(NREQ - 1);
      src_q   <= '0;
      beat_q  <= 4'd0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      src_q   <= src_d;
      beat_q  <= beat_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one FIFO write port among NREQ requesters. Each requester presents a data word and holds it until acknowledged. The arbiter grants one requester at a time for a bounded burst, drives the FIFO write strobe and data, and stalls on FIFO full. It sits directly in front of the team's 8-deep synchronous FIFO and tags each write with its source index.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width
- MAX_BURST, 4, maximum beats per grant (1..16)
- SW, 2, width of source index; must equal clog2(NREQ)
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req  in  NREQ  per-requester request; held with data until ack
- req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW]
- fifo_full  in  1  full flag from the downstream FIFO
- gnt  out  NREQ  registered one-hot grant (all zero when idle)
- ack  out  NREQ  combinational; ack[i] = gnt[i] & req[i] & !fifo_full; data consumed this cycle
- fifo_wr  out  1  combinational write strobe = |ack
- fifo_data  out  DW  req_data slice of the granted requester (0 when gnt==0)
- fifo_src  out  SW  registered index of current owner
- busy  out  1  high in BURST state

## Operation
- State: fsm {IDLE, BURST}, owner[SW-1:0], last[SW-1:0], beat_cnt[3:0].
- Reset values: fsm=IDLE, gnt=0, owner=0, fifo_src=0, beat_cnt=0, last=NREQ-1. Requester 0 therefore has first priority. With gnt=0, ack, fifo_wr and fifo_data are all 0.
- IDLE: gnt=0. If any req bit is set, choose the first set bit scanning last+1, last+2, … modulo NREQ. Load owner and fifo_src, set gnt to one-hot(owner), clear beat_cnt, go to BURST. Arbitration ignores fifo_full.
- BURST: each cycle with ack[owner] increments beat_cnt. fifo_full stalls beats; the grant is held indefinitely and there is no timeout.
- Release from BURST to IDLE on the clock edge when either condition holds:
  - (a) ack in the final beat, i.e. beat_cnt == MAX_BURST-1;
  - (b) req[owner]==0. No ack occurs that cycle.
- On release: gnt→0, last←owner, beat_cnt→0.
- Requests from non-owners are ignored until the next IDLE cycle. A requester may raise req in any cycle. After assertion it must hold req and data stable until its ack.
- Arithmetic: the round-robin scan index wraps modulo NREQ. beat_cnt never exceeds MAX_BURST-1.

## Timing
- Request seen in an IDLE cycle k → gnt valid in cycle k+1. First ack is possible in cycle k+1, so latency from req to first ack is 1 cycle when idle.
- Ack-to-write latency is 0: fifo_wr and fifo_data are valid in the same cycle as ack, and the FIFO samples them at the end of that cycle.
- After a release there is exactly one IDLE cycle with gnt=0. Peak throughput with back-to-back owners is MAX_BURST beats per MAX_BURST+1 cycles.
- fifo_full is used combinationally in the same cycle. A rise in fifo_full blocks that cycle's ack.
- Asynchronous reset mid-burst: gnt, ack, fifo_wr and busy drop immediately on rst_n falling. No partial write is issued.
- Deassertion of rst_n is synchronized externally; the first arbitration happens on the first edge after release.

## Test plan
- Single requester, no full: req[2]=1 continuously with data 0x10,0x11,… (advancing on ack). Required: gnt=0100 from cycle 1; 4 acks with fifo_wr=1 and fifo_data 0x10..0x13, fifo_src=2; one cycle gnt=0; regrant to 2; next burst writes 0x14..0x17.
- All four requesting: req=1111 held. Required grant order 0,1,2,3,0. Each burst is 4 beats; there are 5 cycles between grant starts.
- Full stall: owner 1 with fifo_full=1 for 3 cycles mid-burst after 2 beats. Required:
  - no ack and no fifo_wr while full;
  - gnt held;
  - the burst completes with exactly 2 more beats after full clears.
- Early drop: owner 0 drops req after 1 beat, while req[3]=1. Required: release on that edge; one IDLE cycle; grant to 3 (not 0); last=0.
- Wrap-around: after reset, req=1000 then req=1001. Required: grant 3 first, then 0, since the scan wraps 3→0.
- Reset mid-burst: assert rst_n=0 during beat 2 of owner 1. Required: gnt, ack and fifo_wr go to 0 immediately. After release with req=0011, the first grant goes to requester 0, confirming last reset to NREQ-1.
